ctrl_pipe: RTL
==============

# ctrl_pipe

Parametrised pipelined control unit for the MIPS core. It decodes `op`/`funct` in the Decode stage and carries the resulting control bundle through Execute, a configurable number of Memory stages, and Writeback. It adds an extended instruction subset, per-stage stall/flush, illegal-opcode trapping, and a retired-instruction counter. It sits beside the datapath and feeds the hazard unit.

## Interface
- `MEM_STAGES`, 1: number of Memory pipeline stages; legal range 1..4.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `op` in 6: Decode-stage opcode.
- `funct` in 6: Decode-stage function field.
- `equalID` in 1: Decode-stage register comparison result (rs == rt).
- `stallE` in 1: hold the Execute register and inject a bubble into M1.
- `flushE` in 1: load a bubble into the Execute register.
- `flushM` in 1: load a bubble into M1.
- `branchD`, `jumpD`, `pcsrcD` out 1 each: Decode branch, jump and taken-branch signals.
- `illegalD` out 1: current Decode op/funct is unsupported.
- `alusrcE`, `regdstE`, `linkE` out 1 each: Execute mux controls.
- `alucontrolE` out 3: Execute ALU operation.
- `regwriteE`, `memtoregE` out 1 each: Execute-stage signals for the hazard unit.
- `memwriteM` out 1: memory write enable, taken from M1.
- `regwriteMv`, `memtoregMv` out MEM_STAGES each: per-M-stage flags; bit 0 is M1.
- `regwriteW`, `memtoregW`, `linkW` out 1 each: Writeback controls.
- `illegal_sticky` out 1: set once any illegal instruction passes Decode.
- `retired` out CNT_W: count of valid instructions that reached Writeback.

## Operation
- Bundle fields: valid, regwrite, memtoreg, memwrite, alusrc, regdst, link, alucontrol[2:0]. A bubble is the all-zero bundle.
- ALU codes: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
- Decode for each op (all unlisted fields 0):
  - R-type 000000: regwrite, regdst; ALU code from funct.
    - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
    - Any other funct is illegal.
  - lw 100011: regwrite, alusrc, memtoreg; ADD.
  - sw 101011: memwrite, alusrc; ADD.
  - beq 000100: branch; SUB.
  - bne 000101: branch, ne; SUB.
  - addi 001000: regwrite, alusrc; ADD.
  - andi 001100: regwrite, alusrc; AND.
  - ori 001101: regwrite, alusrc; OR.
  - slti 001010: regwrite, alusrc; SLT.
  - j 000010: jump.
  - jal 000011: jump, regwrite, link.
  - Any other op: illegal.
- `valid` = 1 for every legal decode.
- Illegal instructions:
  - `illegalD` = 1.
  - The bundle is forced to a bubble.
  - `branchD` = `jumpD` = 0.
- `pcsrcD = branchD & (equalID ^ ne)`.
- `branchD`, `jumpD`, `pcsrcD` and `illegalD` are combinational from `op`/`funct`/`equalID`.
- `illegal_sticky` sets on any clock edge where `illegalD` = 1 and `flushE` = 0. It clears only on reset.

## Timing
- Reset asserted: every register, every output-driving flag, `illegal_sticky` and `retired` go to 0 immediately.
- Register E, per edge, in priority order:
  - `flushE`: load bubble.
  - else `stallE`: hold.
  - else: load the Decode bundle.
- Register M1, per edge, in priority order:
  - `flushM` or `stallE`: load bubble.
  - else: load E.
- Registers M2..M(MEM_STAGES) shift unconditionally. Register W loads M(last).
- Latency from Decode:
  - Execute: 1 cycle.
  - M1: 2 cycles.
  - Writeback: MEM_STAGES+2 cycles.
- `flushE` and `stallE` together: flush wins for E. M1 still receives a bubble.
- `retired` increments by 1 on each edge where W.valid = 1. It wraps from all-ones to 0 with no flag.
- Reset released mid-stream: the pipeline restarts empty. The first valid W appears MEM_STAGES+2 cycles after the first legal Decode.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode and funct constants;
  - ALU code constants;
  - the control bundle struct and the bubble constant.
- One sub-module, `ctrl_decode`: combinational op/funct to bundle, plus `illegal` and `ne`.
- Pipeline registers are generated per stage using MEM_STAGES.

## Test plan
- Reset and lw (MEM_STAGES=2):
  - Hold reset low, then release. All outputs are 0.
  - Issue lw (100011). `regwriteE` = `memtoregE` = 1 one cycle later; `memtoregW` = 1 four cycles after issue; `retired` = 1.
- Branch resolution:
  - bne with `equalID`=0 gives `pcsrcD`=1.
  - bne with `equalID`=1 gives `pcsrcD`=0.
  - beq with `equalID`=1 gives `pcsrcD`=1.
  - `alucontrolE` = 110 the next cycle.
- Stall then flush:
  - Issue addi with `stallE`=1 for 2 cycles. E holds addi; M1 receives bubbles; `regwriteMv[0]` = 0.
  - Assert `flushE` and `stallE` together. E becomes a bubble.
- Illegal instructions:
  - op 111111 gives `illegalD`=1; `illegal_sticky` = 1 after the edge; no increment of `retired`.
  - R-type funct 000000 behaves the same.
  - The flag persists until reset.
- jal: `linkW` = `regwriteW` = 1 exactly MEM_STAGES+2 cycles after issue, for MEM_STAGES = 1 and 4.
- Counter wrap: with CNT_W=4, retire 17 R-type ADDs; `retired` = 1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined MIPS control unit: opcode/funct values,
// ALU operation codes and the control bundle carried down the pipeline.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic       link;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// Decode inputs, stall/flush controls and per-stage control outputs of ctrl_pipe.
interface ctrl_pipe_if #(
  parameter int MEM_STAGES = 1,
  parameter int CNT_W      = 32
);
  logic [5:0]            op;
  logic [5:0]            funct;
  logic                  equalID;
  logic                  stallE;
  logic                  flushE;
  logic                  flushM;
  logic                  branchD;
  logic                  jumpD;
  logic                  pcsrcD;
  logic                  illegalD;
  logic                  alusrcE;
  logic                  regdstE;
  logic                  linkE;
  logic [2:0]            alucontrolE;
  logic                  regwriteE;
  logic                  memtoregE;
  logic                  memwriteM;
  logic [MEM_STAGES-1:0] regwriteMv;
  logic [MEM_STAGES-1:0] memtoregMv;
  logic                  regwriteW;
  logic                  memtoregW;
  logic                  linkW;
  logic                  illegal_sticky;
  logic [CNT_W-1:0]      retired;

  modport master (
    output op, funct, equalID, stallE, flushE, flushM,
    input  branchD, jumpD, pcsrcD, illegalD, alusrcE, regdstE, linkE, alucontrolE,
           regwriteE, memtoregE, memwriteM, regwriteMv, memtoregMv,
           regwriteW, memtoregW, linkW, illegal_sticky, retired
  );

  modport slave (
    input  op, funct, equalID, stallE, flushE, flushM,
    output branchD, jumpD, pcsrcD, illegalD, alusrcE, regdstE, linkE, alucontrolE,
           regwriteE, memtoregE, memwriteM, regwriteMv, memtoregMv,
           regwriteW, memtoregW, linkW, illegal_sticky, retired
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational op/funct decoder producing the control bundle, branch/jump
// qualifiers and the illegal-instruction indication.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       branch,
  output logic       jump,
  output logic       ne,
  output logic       illegal
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    ctrl    = BUBBLE;
    branch  = 1'b0;
    jump    = 1'b0;
    ne      = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alucontrol = ALU_ADD;
          FN_SUB:  ctrl.alucontrol = ALU_SUB;
          FN_AND:  ctrl.alucontrol = ALU_AND;
          FN_OR:   ctrl.alucontrol = ALU_OR;
          FN_SLT:  ctrl.alucontrol = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_LW:   begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.memtoreg = 1'b1; ctrl.alucontrol = ALU_ADD; end
      OP_SW:   begin ctrl.memwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alucontrol = ALU_ADD; end
      OP_BEQ:  begin branch = 1'b1; ctrl.alucontrol = ALU_SUB; end
      OP_BNE:  begin branch = 1'b1; ne = 1'b1; ctrl.alucontrol = ALU_SUB; end
      OP_ADDI: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alucontrol = ALU_ADD; end
      OP_ANDI: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alucontrol = ALU_AND; end
      OP_ORI:  begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alucontrol = ALU_OR;  end
      OP_SLTI: begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.alucontrol = ALU_SLT; end
      OP_J:    jump = 1'b1;
      OP_JAL:  begin jump = 1'b1; ctrl.regwrite = 1'b1; ctrl.link = 1'b1; end
      default: illegal = 1'b1;
    endcase

    // An illegal instruction must not leak any partially decoded control.
    if (illegal) begin
      ctrl   = BUBBLE;
      branch = 1'b0;
      jump   = 1'b0;
      ne     = 1'b0;
    end else begin
      ctrl.valid = 1'b1;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined MIPS control unit: carries the decoded bundle through E, M1..Mn and W
// with stall/flush, illegal-opcode trapping and a retired-instruction counter.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int MEM_STAGES = 1,
  parameter int CNT_W      = 32
) (
  input logic        clk,
  input logic        reset,
  ctrl_pipe_if.slave bus
);

  ctrl_t            dec_ctrl;
  ctrl_t            e_q;
  ctrl_t            m_q [MEM_STAGES];
  ctrl_t            w_q;
  logic             dec_branch, dec_jump, dec_ne, dec_illegal;
  logic             sticky_q;
  logic [CNT_W-1:0] retired_q;
  logic             unused_w;

  ctrl_decode u_decode (
    .op      (bus.op),
    .funct   (bus.funct),
    .ctrl    (dec_ctrl),
    .branch  (dec_branch),
    .jump    (dec_jump),
    .ne      (dec_ne),
    .illegal (dec_illegal)
  );

  assign bus.branchD  = dec_branch;
  assign bus.jumpD    = dec_jump;
  assign bus.illegalD = dec_illegal;
  assign bus.pcsrcD   = dec_branch & (bus.equalID ^ dec_ne);

  // NOTE: state is updated with non-blocking assignments so stages shift in lockstep.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            e_q <= BUBBLE;
    else if (bus.flushE)   e_q <= BUBBLE;
    else if (!bus.stallE)  e_q <= dec_ctrl;
  end

  for (genvar i = 0; i < MEM_STAGES; i++) begin : g_mem
    if (i == 0) begin : g_m1
      // A held E register must not also advance, so M1 takes a bubble on stall.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          m_q[0] <= BUBBLE;
        else if (bus.flushM || bus.stallE)   m_q[0] <= BUBBLE;
        else                                 m_q[0] <= e_q;
      end
    end else begin : g_mn
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) m_q[i] <= BUBBLE;
        else        m_q[i] <= m_q[i-1];
      end
    end
    assign bus.regwriteMv[i] = m_q[i].regwrite;
    assign bus.memtoregMv[i] = m_q[i].memtoreg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_q       <= BUBBLE;
      sticky_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      w_q <= m_q[MEM_STAGES-1];
      if (dec_illegal && !bus.flushE) sticky_q <= 1'b1;
      if (w_q.valid) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.alusrcE        = e_q.alusrc;
  assign bus.regdstE        = e_q.regdst;
  assign bus.linkE          = e_q.link;
  assign bus.alucontrolE    = e_q.alucontrol;
  assign bus.regwriteE      = e_q.regwrite;
  assign bus.memtoregE      = e_q.memtoreg;
  assign bus.memwriteM      = m_q[0].memwrite;
  assign bus.regwriteW      = w_q.regwrite;
  assign bus.memtoregW      = w_q.memtoreg;
  assign bus.linkW          = w_q.link;
  assign bus.illegal_sticky = sticky_q;
  assign bus.retired        = retired_q;

  // Writeback only consumes a subset of the bundle.
  assign unused_w = ^{w_q.memwrite, w_q.alusrc, w_q.regdst, w_q.alucontrol};

endmodule
